// File: rtl/sc_backg_lane_datapath.sv
// Purpose : datapath for one Frogger background lane (pattern rotate, speed prescaler, snapshot/compare).
// Latency : every output is registered; a command issued in cycle N is visible in cycle N+1.
// Backpr. : none; the controller issues one command set per clock and every command is always accepted.
//
// Ports:
//   SC_BACKGLANE_CLOCK_50                      clock
//   SC_BACKGLANE_RESET_InHigh                  synchronous active-high reset
//   SC_BACKGLANE_clear_InLow                   lane <= INIT_PATTERN, prescaler <= 0
//   SC_BACKGLANE_load_InLow                    lane <= data_In
//   SC_BACKGLANE_shiftselection_In             10 rotate left, 01 rotate right, else hold
//   SC_BACKGLANE_upcount_InLow                 advance the prescaler one step
//   SC_BACKGLANE_loadLastRegister_InLow        last <= lane (pre-edge value)
//   SC_BACKGLANE_data_In / frog_In / goal_In   load value, one-hot frog column, goal flag
//   SC_BACKGLANE_T0_OutLow                     low while prescaler sits at terminal count
//   SC_BACKGLANE_LastRegisterComparator_OutLow 11 collision, 10 snapshot needed, 00 idle
//   SC_BACKGLANE_lane_Out / last_Out           lane register and last snapshot
module sc_backg_lane_datapath #(
    parameter int                   DATAWIDTH    = 8,
    parameter logic [DATAWIDTH-1:0] INIT_PATTERN = 8'b00110011,
    parameter int                   COUNT_WIDTH  = 23,
    parameter int                   COUNT_LIMIT  = 5000000
) (
    input  logic                 SC_BACKGLANE_CLOCK_50,
    input  logic                 SC_BACKGLANE_RESET_InHigh,
    input  logic                 SC_BACKGLANE_clear_InLow,
    input  logic                 SC_BACKGLANE_load_InLow,
    input  logic [1:0]           SC_BACKGLANE_shiftselection_In,
    input  logic                 SC_BACKGLANE_upcount_InLow,
    input  logic                 SC_BACKGLANE_loadLastRegister_InLow,
    input  logic [DATAWIDTH-1:0] SC_BACKGLANE_data_In,
    input  logic [DATAWIDTH-1:0] SC_BACKGLANE_frog_In,
    input  logic                 SC_BACKGLANE_goal_In,
    output logic                 SC_BACKGLANE_T0_OutLow,
    output logic [1:0]           SC_BACKGLANE_LastRegisterComparator_OutLow,
    output logic [DATAWIDTH-1:0] SC_BACKGLANE_lane_Out,
    output logic [DATAWIDTH-1:0] SC_BACKGLANE_last_Out
);

    localparam logic [COUNT_WIDTH-1:0] TERM_CNT = COUNT_WIDTH'(COUNT_LIMIT - 1);

    logic [DATAWIDTH-1:0]   r_lane;
    logic [DATAWIDTH-1:0]   r_last;
    logic [COUNT_WIDTH-1:0] r_cnt;
    logic                   r_t0_n;
    logic [1:0]             r_cmp;

    logic [DATAWIDTH-1:0]   w_lane_next;
    logic [COUNT_WIDTH-1:0] w_cnt_next;
    logic [1:0]             w_cmp_next;

    // Lane next-state: clear beats load beats rotate.
    always_comb begin
        w_lane_next = r_lane;
        if (!SC_BACKGLANE_clear_InLow) begin
            w_lane_next = INIT_PATTERN;
        end else if (!SC_BACKGLANE_load_InLow) begin
            w_lane_next = SC_BACKGLANE_data_In;
        end else begin
            case (SC_BACKGLANE_shiftselection_In)
                2'b10:   w_lane_next = {r_lane[DATAWIDTH-2:0], r_lane[DATAWIDTH-1]};
                2'b01:   w_lane_next = {r_lane[0], r_lane[DATAWIDTH-1:1]};
                default: w_lane_next = r_lane;
            endcase
        end
    end

    // Prescaler next-state: clear swallows a simultaneous upcount strobe.
    always_comb begin
        w_cnt_next = r_cnt;
        if (!SC_BACKGLANE_clear_InLow) begin
            w_cnt_next = '0;
        end else if (!SC_BACKGLANE_upcount_InLow) begin
            w_cnt_next = (r_cnt == TERM_CNT) ? '0 : r_cnt + 1'b1;
        end
    end

    // Comparator works on pre-edge state; collision outranks the snapshot request.
    always_comb begin
        w_cmp_next = 2'b00;
        if ((r_lane & SC_BACKGLANE_frog_In) != '0) begin
            w_cmp_next = 2'b11;
        end else if (SC_BACKGLANE_goal_In && (r_last != r_lane)) begin
            w_cmp_next = 2'b10;
        end
    end

    always_ff @(posedge SC_BACKGLANE_CLOCK_50) begin
        if (SC_BACKGLANE_RESET_InHigh) begin
            r_lane <= INIT_PATTERN;
            r_last <= '0;
            r_cnt  <= '0;
            r_t0_n <= 1'b1;
            r_cmp  <= 2'b00;
        end else begin
            r_lane <= w_lane_next;
            r_cnt  <= w_cnt_next;
            // T0 is derived from the next count so it tracks the counter register exactly.
            r_t0_n <= (w_cnt_next != TERM_CNT);
            r_cmp  <= w_cmp_next;
            if (!SC_BACKGLANE_loadLastRegister_InLow) begin
                r_last <= r_lane;
            end
        end
    end

    assign SC_BACKGLANE_T0_OutLow                     = r_t0_n;
    assign SC_BACKGLANE_LastRegisterComparator_OutLow = r_cmp;
    assign SC_BACKGLANE_lane_Out                      = r_lane;
    assign SC_BACKGLANE_last_Out                      = r_last;

endmodule
